// File: rtl/gemm_pkg.sv
// Shared types and sizing helpers for the weight-stationary GEMM stream engine.
package gemm_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } gemm_state_e;

  function automatic int gemm_lat(input int in_dim, input int out_dim);
    return in_dim + out_dim;
  endfunction

  // Wide enough that IN_DIM full-scale products can never overflow.
  function automatic int gemm_acc_w(input int data_w, input int in_dim);
    return 2 * data_w + $clog2(in_dim);
  endfunction

endpackage

// File: rtl/gemm_ws_stream_if.sv
// Stream, weight-load and status bundle for gemm_ws_stream.
interface gemm_ws_stream_if #(
  parameter int IN_DIM  = 4,
  parameter int OUT_DIM = 4,
  parameter int DATA_W  = 8,
  parameter int OUT_W   = 8
);
  localparam int ROW_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;

  logic                           w_load_valid;
  logic                           w_load_ready;
  logic [ROW_W-1:0]               w_load_row;
  logic [OUT_DIM-1:0][DATA_W-1:0] w_load_data;
  logic                           w_commit;
  logic                           w_commit_done;
  logic                           in_valid;
  logic                           in_ready;
  logic [IN_DIM-1:0][DATA_W-1:0]  in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [OUT_DIM-1:0][OUT_W-1:0]  out_data;
  logic                           busy;

  modport master (
    output w_load_valid, w_load_row, w_load_data, w_commit, in_valid, in_data, out_ready,
    input  w_load_ready, w_commit_done, in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  w_load_valid, w_load_row, w_load_data, w_commit, in_valid, in_data, out_ready,
    output w_load_ready, w_commit_done, in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/gemm_ws_pe.sv
// One systolic processing element: stationary weight, multiply-add, activation pass-through.
module gemm_ws_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              w_load,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [ACC_W-1:0]  p_in,
  output logic [DATA_W-1:0] a_out,
  output logic [ACC_W-1:0]  p_out
);
  logic [DATA_W-1:0]   w_q;
  logic [2*DATA_W-1:0] prod;

  assign prod = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, w_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q   <= '0;
      a_out <= '0;
      p_out <= '0;
    end else begin
      if (w_load) w_q <= w_in;
      if (en) begin
        a_out <= a_in;
        p_out <= p_in + ACC_W'(prod);
      end
    end
  end
endmodule

// File: rtl/gemm_ws_stream.sv
// Weight-stationary systolic matrix-vector engine with double-buffered weights,
// valid/ready flow control and a drain-and-swap commit controller.
module gemm_ws_stream
  import gemm_pkg::*;
#(
  parameter int IN_DIM   = 4,
  parameter int OUT_DIM  = 4,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = gemm_acc_w(DATA_W, IN_DIM),
  parameter int OUT_W    = DATA_W,
  parameter bit SATURATE = 1'b0
) (
  input logic             clk,
  input logic             reset,
  gemm_ws_stream_if.slave bus
);
  localparam int LAT   = gemm_lat(IN_DIM, OUT_DIM);
  localparam int OCC_W = $clog2(LAT + 1);

  gemm_state_e state, state_nxt;
  logic        commit_pending, swap, en, accept, out_hs, w_wr;
  logic [OCC_W-1:0] occ;
  logic [LAT-1:0]   vld;
  logic [IN_DIM-1:0][OUT_DIM-1:0][DATA_W-1:0] shadow;
  logic [IN_DIM-1:0][OUT_DIM-1:0][DATA_W-1:0] a_row;
  logic [IN_DIM:0][OUT_DIM-1:0][ACC_W-1:0]    p_col;
  logic [IN_DIM-1:0][DATA_W-1:0]              a_unused;

  assign bus.out_valid = vld[LAT-1];
  assign en     = !(vld[LAT-1] && !bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign out_hs = vld[LAT-1] && bus.out_ready;
  assign w_wr   = bus.w_load_valid && bus.w_load_ready && (int'(bus.w_load_row) < IN_DIM);
  assign bus.busy = (occ != '0) || (state != RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (commit_pending) state_nxt = (occ == '0) ? SWAP : DRAIN;
      DRAIN:   if (occ == '0) state_nxt = SWAP;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    swap              = 1'b0;
    bus.w_load_ready  = 1'b1;
    bus.w_commit_done = 1'b0;
    bus.in_ready      = 1'b0;
    case (state)
      RUN:  bus.in_ready = en && !commit_pending && !reset;
      SWAP: begin
        swap              = 1'b1;
        bus.w_load_ready  = 1'b0;
        bus.w_commit_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_pending <= 1'b0;
      occ            <= '0;
      vld            <= '0;
      shadow         <= '0;
    end else begin
      if (swap)                              commit_pending <= 1'b0;
      else if (state == RUN && bus.w_commit) commit_pending <= 1'b1;
      if (accept && !out_hs)      occ <= occ + OCC_W'(1);
      else if (!accept && out_hs) occ <= occ - OCC_W'(1);
      if (en) vld <= {vld[LAT-2:0], accept};
      if (w_wr) shadow[bus.w_load_row] <= bus.w_load_data;
    end
  end

  // Row j is delayed j+1 cycles so its activation meets the partial sum coming down.
  for (genvar j = 0; j < IN_DIM; j++) begin : g_in_skew
    logic [DATA_W-1:0] sk [0:j];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k <= j; k++) sk[k] <= '0;
      end else if (en) begin
        sk[0] <= accept ? bus.in_data[j] : '0;
        for (int k = 1; k <= j; k++) sk[k] <= sk[k-1];
      end
    end
    assign a_row[j][0] = sk[j];
  end

  for (genvar i = 0; i < OUT_DIM; i++) begin : g_col
    assign p_col[0][i] = '0;
    for (genvar j = 0; j < IN_DIM; j++) begin : g_row
      logic [DATA_W-1:0] a_o;
      gemm_ws_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .w_load (swap),
        .w_in   (shadow[j][i]),
        .a_in   (a_row[j][i]),
        .p_in   (p_col[j][i]),
        .a_out  (a_o),
        .p_out  (p_col[j+1][i])
      );
      if (i < OUT_DIM - 1) begin : g_fwd
        assign a_row[j][i+1] = a_o;
      end else begin : g_tail
        assign a_unused[j] = a_o;
      end
    end

    // Column i finishes OUT_DIM-1-i cycles early; delay it so all columns align.
    localparam int D = OUT_DIM - 1 - i;
    logic [OUT_W-1:0] y;
    assign y = (SATURATE && (|p_col[IN_DIM][i][ACC_W-1:OUT_W])) ? '1 : p_col[IN_DIM][i][OUT_W-1:0];
    if (D == 0) begin : g_nodly
      assign bus.out_data[i] = y;
    end else begin : g_dly
      logic [OUT_W-1:0] dq [0:D-1];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < D; k++) dq[k] <= '0;
        end else if (en) begin
          dq[0] <= y;
          for (int k = 1; k < D; k++) dq[k] <= dq[k-1];
        end
      end
      assign bus.out_data[i] = dq[D-1];
    end
  end
endmodule

// File: tb/tb_gemm_ws_stream.sv
// Directed bench for gemm_ws_stream (2x2, 8-bit); wrap and saturate instances run in lockstep.
module tb_gemm_ws_stream;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gemm_ws_stream_if #(.IN_DIM(2), .OUT_DIM(2), .DATA_W(8), .OUT_W(8)) bw ();
  gemm_ws_stream_if #(.IN_DIM(2), .OUT_DIM(2), .DATA_W(8), .OUT_W(8)) bs ();

  assign bs.w_load_valid = bw.w_load_valid;
  assign bs.w_load_row   = bw.w_load_row;
  assign bs.w_load_data  = bw.w_load_data;
  assign bs.w_commit     = bw.w_commit;
  assign bs.in_valid     = bw.in_valid;
  assign bs.in_data      = bw.in_data;
  assign bs.out_ready    = bw.out_ready;

  gemm_ws_stream #(.IN_DIM(2), .OUT_DIM(2), .DATA_W(8), .OUT_W(8), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .bus(bw));
  gemm_ws_stream #(.IN_DIM(2), .OUT_DIM(2), .DATA_W(8), .OUT_W(8), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .bus(bs));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pk(input logic [7:0] e0, input logic [7:0] e1);
    return {e1, e0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] x0, input logic [7:0] x1);
    bw.in_valid = 1'b1;
    bw.in_data  = {x1, x0};
    #1;
    chk("send_in_ready", 32'(bw.in_ready), 1);
    tick();
    bw.in_valid = 1'b0;
  endtask

  task automatic load_row(input int r, input logic [7:0] w0, input logic [7:0] w1, input logic commit);
    bw.w_load_valid = 1'b1;
    bw.w_load_row   = 1'(r);
    bw.w_load_data  = {w1, w0};
    bw.w_commit     = commit;
    tick();
    bw.w_load_valid = 1'b0;
    bw.w_commit     = 1'b0;
  endtask

  task automatic wait_out(input int start, output int n);
    n = start;
    while (!bw.out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bw.out_valid) chk("out_timeout", 0, 1);
  endtask

  task automatic wait_swap();
    int n = 0;
    while (!bw.w_commit_done && n < 20) begin
      tick();
      n++;
    end
    chk("swap_seen", 32'(bw.w_commit_done), 1);
    chk("swap_w_load_ready", 32'(bw.w_load_ready), 0);
    chk("swap_in_ready", 32'(bw.in_ready), 0);
  endtask

  initial begin
    int n;
    int nres;
    logic saw;
    logic [15:0] res [0:3];

    reset = 1'b1;
    bw.w_load_valid = 1'b0; bw.w_load_row = '0; bw.w_load_data = '0;
    bw.w_commit = 1'b0; bw.in_valid = 1'b0; bw.in_data = '0; bw.out_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready", 32'(bw.in_ready), 0);
    chk("rst_w_load_ready", 32'(bw.w_load_ready), 1);
    chk("rst_out_valid", 32'(bw.out_valid), 0);
    chk("rst_busy", 32'(bw.busy), 0);
    chk("rst_commit_done", 32'(bw.w_commit_done), 0);
    chk("rst_out_data", 32'(bw.out_data), 0);
    reset = 1'b0;
    #1;
    chk("run_in_ready", 32'(bw.in_ready), 1);

    // 1: load, commit together with last row write, single vector latency
    load_row(0, 8'd3, 8'd0, 1'b0);
    load_row(1, 8'd0, 8'd2, 1'b1);
    chk("t1_pending_in_ready", 32'(bw.in_ready), 0);
    wait_swap();
    tick();
    chk("t1_done_pulse_clear", 32'(bw.w_commit_done), 0);
    send(8'd2, 8'd5);
    wait_out(1, n);
    chk("t1_latency", 32'(n), 4);
    chk("t1_data", 32'(bw.out_data), 32'(pk(8'd6, 8'd10)));
    chk("t1_data_sat", 32'(bs.out_data), 32'(pk(8'd6, 8'd10)));
    tick();
    chk("t1_out_valid_drop", 32'(bw.out_valid), 0);
    chk("t1_idle", 32'(bw.busy), 0);

    // 2: back-to-back vectors
    send(8'd2, 8'd5);
    send(8'd3, 8'd2);
    wait_out(2, n);
    chk("t2_latency", 32'(n), 4);
    chk("t2_first", 32'(bw.out_data), 32'(pk(8'd6, 8'd10)));
    tick();
    chk("t2_second_valid", 32'(bw.out_valid), 1);
    chk("t2_second", 32'(bw.out_data), 32'(pk(8'd9, 8'd4)));
    tick();
    chk("t2_end", 32'(bw.out_valid), 0);

    // 3: backpressure for 3 cycles
    send(8'd2, 8'd5);
    send(8'd3, 8'd2);
    wait_out(2, n);
    bw.out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t3_hold_valid", 32'(bw.out_valid), 1);
      chk("t3_hold_data", 32'(bw.out_data), 32'(pk(8'd6, 8'd10)));
      chk("t3_hold_in_ready", 32'(bw.in_ready), 0);
      tick();
    end
    bw.out_ready = 1'b1;
    #1;
    chk("t3_release_first", 32'(bw.out_data), 32'(pk(8'd6, 8'd10)));
    tick();
    chk("t3_second_valid", 32'(bw.out_valid), 1);
    chk("t3_second", 32'(bw.out_data), 32'(pk(8'd9, 8'd4)));
    tick();
    chk("t3_end", 32'(bw.out_valid), 0);

    // 4: commit with two vectors in flight -> drain on old weights, then swap
    send(8'd2, 8'd5);
    send(8'd3, 8'd2);
    load_row(0, 8'd1, 8'd1, 1'b0);
    load_row(1, 8'd1, 8'd1, 1'b1);
    nres = 0;
    saw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bw.out_valid && nres < 4) begin
        res[nres] = bw.out_data;
        nres++;
      end
      if (bw.w_commit_done) break;
      if (bw.in_ready) saw = 1'b1;
      tick();
    end
    chk("t4_swap_seen", 32'(bw.w_commit_done), 1);
    chk("t4_drain_in_ready", 32'(saw), 0);
    chk("t4_old_count", 32'(nres), 2);
    chk("t4_old_first", 32'(res[0]), 32'(pk(8'd6, 8'd10)));
    chk("t4_old_second", 32'(res[1]), 32'(pk(8'd9, 8'd4)));
    tick();
    send(8'd2, 8'd5);
    wait_out(1, n);
    chk("t4_new", 32'(bw.out_data), 32'(pk(8'd7, 8'd7)));
    tick();

    // 5: full-scale wrap vs saturate
    load_row(0, 8'd255, 8'd255, 1'b0);
    load_row(1, 8'd255, 8'd255, 1'b1);
    wait_swap();
    tick();
    send(8'd255, 8'd255);
    wait_out(1, n);
    chk("t5_wrap", 32'(bw.out_data), 32'(pk(8'd2, 8'd2)));
    chk("t5_sat", 32'(bs.out_data), 32'(pk(8'd255, 8'd255)));
    tick();

    // 6: reset with three vectors in flight
    send(8'd1, 8'd1);
    send(8'd2, 8'd2);
    send(8'd3, 8'd3);
    chk("t6_busy", 32'(bw.busy), 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_out_valid", 32'(bw.out_valid), 0);
    chk("t6_rst_busy", 32'(bw.busy), 0);
    chk("t6_rst_data", 32'(bw.out_data), 0);
    chk("t6_rst_data_sat", 32'(bs.out_data), 0);
    chk("t6_rst_w_load_ready", 32'(bw.w_load_ready), 1);
    tick();
    reset = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bw.out_valid) saw = 1'b1;
      tick();
    end
    chk("t6_no_stale_out", 32'(saw), 0);
    send(8'd9, 8'd9);
    wait_out(1, n);
    chk("t6_latency", 32'(n), 4);
    chk("t6_cleared_weights", 32'(bw.out_data), 0);
    chk("t6_cleared_weights_sat", 32'(bs.out_data), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
